tri_vertex_setup: RTL and testbench

//  Upstream setup stage for the VGA triangle rasteriser. It accepts one triangle (three 12-bit vertices) over a

---
 rtl/tri_vertex_setup.sv | 178 +++++++++++++++++
 tb/tb_tri_vertex_setup.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tri_vertex_setup.sv
// Triangle setup stage: latches three vertices, computes |2*area| with one shared multiplier,
// and commits the staged triangle to the active output bank only on a frame_start pulse.
module tri_vertex_setup #(
  parameter int CW = 12,
  parameter int AW = 22
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_x1,
  input  logic [CW-1:0] in_y1,
  input  logic [CW-1:0] in_x2,
  input  logic [CW-1:0] in_y2,
  input  logic [CW-1:0] in_x3,
  input  logic [CW-1:0] in_y3,
  input  logic          frame_start,
  output logic [CW-1:0] out_x1,
  output logic [CW-1:0] out_y1,
  output logic [CW-1:0] out_x2,
  output logic [CW-1:0] out_y2,
  output logic [CW-1:0] out_x3,
  output logic [CW-1:0] out_y3,
  output logic [AW-1:0] out_area2,
  output logic          out_valid,
  output logic          out_degen,
  output logic          out_sat,
  output logic          busy
);

  localparam int PW   = 2*CW + 2;
  localparam int ACCW = PW + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL1 = 3'd1,
    MUL2 = 3'd2,
    MUL3 = 3'd3,
    ABS  = 3'd4,
    PEND = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0][CW-1:0]      stg_x_q, stg_x_d, stg_y_q, stg_y_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic [AW-1:0]           stg_area_q, stg_area_d;
  logic                    stg_sat_q, stg_sat_d, stg_degen_q, stg_degen_d;
  logic [2:0][CW-1:0]      out_x_q, out_x_d, out_y_q, out_y_d;
  logic [AW-1:0]           out_area_q, out_area_d;
  logic                    out_valid_q, out_valid_d, out_sat_q, out_sat_d, out_degen_q, out_degen_d;

  logic [CW-1:0]           mul_x_s, dif_a_s, dif_b_s;
  logic signed [CW:0]      diff_s;
  logic signed [PW-1:0]    mul_op_s, dif_op_s, prod_s;
  logic signed [ACCW-1:0]  prod_ext_s;
  logic [ACCW-1:0]         mag_s;
  logic                    sat_s;

  // Shared multiplier operand selection: term k is x_k * (y_{k+1} - y_{k+2}).
  always_comb begin
    mul_x_s = {CW{1'b0}};
    dif_a_s = {CW{1'b0}};
    dif_b_s = {CW{1'b0}};
    case (state_q)
      MUL1:    begin mul_x_s = stg_x_q[0]; dif_a_s = stg_y_q[1]; dif_b_s = stg_y_q[2]; end
      MUL2:    begin mul_x_s = stg_x_q[1]; dif_a_s = stg_y_q[2]; dif_b_s = stg_y_q[0]; end
      MUL3:    begin mul_x_s = stg_x_q[2]; dif_a_s = stg_y_q[0]; dif_b_s = stg_y_q[1]; end
      default: begin mul_x_s = {CW{1'b0}}; dif_a_s = {CW{1'b0}}; dif_b_s = {CW{1'b0}}; end
    endcase
  end

  assign diff_s     = $signed({1'b0, dif_a_s}) - $signed({1'b0, dif_b_s});
  assign mul_op_s   = {{(PW-CW){1'b0}}, mul_x_s};
  assign dif_op_s   = {{(PW-CW-1){diff_s[CW]}}, diff_s};
  assign prod_s     = mul_op_s * dif_op_s;
  assign prod_ext_s = {prod_s[PW-1], prod_s};
  assign mag_s      = acc_q[ACCW-1] ? ({ACCW{1'b0}} - acc_q) : acc_q;
  assign sat_s      = (mag_s[ACCW-1:AW] != {(ACCW-AW){1'b0}});

  // Next-state and datapath updates for the setup sequence.
  always_comb begin
    state_d     = state_q;
    stg_x_d     = stg_x_q;
    stg_y_d     = stg_y_q;
    acc_d       = acc_q;
    stg_area_d  = stg_area_q;
    stg_sat_d   = stg_sat_q;
    stg_degen_d = stg_degen_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_area_d  = out_area_q;
    out_valid_d = out_valid_q;
    out_sat_d   = out_sat_q;
    out_degen_d = out_degen_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          stg_x_d = {in_x3, in_x2, in_x1};
          stg_y_d = {in_y3, in_y2, in_y1};
          state_d = MUL1;
        end else begin
          state_d = IDLE;
        end
      end
      MUL1: begin acc_d = prod_ext_s;         state_d = MUL2; end
      MUL2: begin acc_d = acc_q + prod_ext_s; state_d = MUL3; end
      MUL3: begin acc_d = acc_q + prod_ext_s; state_d = ABS;  end
      ABS: begin
        stg_area_d  = sat_s ? {AW{1'b1}} : mag_s[AW-1:0];
        stg_sat_d   = sat_s;
        stg_degen_d = (acc_q == {ACCW{1'b0}});
        state_d     = PEND;
      end
      PEND: begin
        // Commit only at a frame boundary so downstream never sees a half-updated triangle.
        if (frame_start) begin
          out_x_d     = stg_x_q;
          out_y_d     = stg_y_q;
          out_area_d  = stg_area_q;
          out_sat_d   = stg_sat_q;
          out_degen_d = stg_degen_q;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = PEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, staging and active-bank registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      stg_x_q     <= {(3*CW){1'b0}};
      stg_y_q     <= {(3*CW){1'b0}};
      acc_q       <= {ACCW{1'b0}};
      stg_area_q  <= {AW{1'b0}};
      stg_sat_q   <= 1'b0;
      stg_degen_q <= 1'b0;
      out_x_q     <= {(3*CW){1'b0}};
      out_y_q     <= {(3*CW){1'b0}};
      out_area_q  <= {AW{1'b0}};
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      out_degen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stg_x_q     <= stg_x_d;
      stg_y_q     <= stg_y_d;
      acc_q       <= acc_d;
      stg_area_q  <= stg_area_d;
      stg_sat_q   <= stg_sat_d;
      stg_degen_q <= stg_degen_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_area_q  <= out_area_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
      out_degen_q <= out_degen_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign busy      = (state_q != IDLE);
  assign out_x1    = out_x_q[0];
  assign out_y1    = out_y_q[0];
  assign out_x2    = out_x_q[1];
  assign out_y2    = out_y_q[1];
  assign out_x3    = out_x_q[2];
  assign out_y3    = out_y_q[2];
  assign out_area2 = out_area_q;
  assign out_valid = out_valid_q;
  assign out_degen = out_degen_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_tri_vertex_setup.sv
// Directed bench for tri_vertex_setup: reset, area/degenerate/saturation cases, frame gating, reset in PEND.
module tb_tri_vertex_setup;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_x1 = 12'd0, in_y1 = 12'd0, in_x2 = 12'd0, in_y2 = 12'd0, in_x3 = 12'd0, in_y3 = 12'd0;
  logic        frame_start = 1'b0;
  logic [11:0] out_x1, out_y1, out_x2, out_y2, out_x3, out_y3;
  logic [21:0] out_area2;
  logic        out_valid, out_degen, out_sat, busy;

  int checks = 0;
  int errors = 0;

  tri_vertex_setup #(.CW(12), .AW(22)) dut (
    .CLOCK_50(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x1(in_x1), .in_y1(in_y1), .in_x2(in_x2), .in_y2(in_y2), .in_x3(in_x3), .in_y3(in_y3),
    .frame_start(frame_start),
    .out_x1(out_x1), .out_y1(out_y1), .out_x2(out_x2), .out_y2(out_y2), .out_x3(out_x3), .out_y3(out_y3),
    .out_area2(out_area2), .out_valid(out_valid), .out_degen(out_degen), .out_sat(out_sat), .busy(busy)
  );

  always #10 clk = ~clk;

  // Present a triangle and return just after the accepting edge (first MUL1 cycle).
  task automatic handshake(input int x1, input int y1, input int x2, input int y2, input int x3, input int y3);
    int n;
    @(negedge clk);
    in_x1 = x1[11:0]; in_y1 = y1[11:0]; in_x2 = x2[11:0];
    in_y2 = y2[11:0]; in_x3 = x3[11:0]; in_y3 = y3[11:0];
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL handshake_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Pulse frame_start for one cycle starting at the next falling edge.
  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl in_ready=%0b busy=%0b out_valid=%0b required 0/0/0", in_ready, busy, out_valid);
    end
    checks++;
    if ({out_x1, out_y1, out_x2, out_y2, out_x3, out_y3} !== 72'd0 || out_area2 !== 22'd0 ||
        out_degen !== 1'b0 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs area=%0d x1=%0d degen=%0b sat=%0b required all 0", out_area2, out_x1, out_degen, out_sat);
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready in_ready=%0b required=1", in_ready);
    end
  endtask

  task automatic test_area();
    handshake(286, 36, 300, 300, 1000, 500);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL area_pend out_valid=%0b in_ready=%0b busy=%0b required 0/0/1", out_valid, in_ready, busy);
    end
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    @(negedge clk);
    checks++;
    if (out_area2 !== 22'd182000 || out_degen !== 1'b0 || out_sat !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL area_value area=%0d degen=%0b sat=%0b valid=%0b required 182000/0/0/1", out_area2, out_degen, out_sat, out_valid);
    end
    checks++;
    if (out_x1 !== 12'd286 || out_y1 !== 12'd36 || out_x2 !== 12'd300 || out_y2 !== 12'd300 ||
        out_x3 !== 12'd1000 || out_y3 !== 12'd500) begin
      errors++;
      $display("FAIL area_vertices x1=%0d y1=%0d x3=%0d y3=%0d required 286/36/1000/500", out_x1, out_y1, out_x3, out_y3);
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL area_idle in_ready=%0b busy=%0b required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_degenerate();
    handshake(0, 0, 10, 10, 20, 20);
    repeat (4) @(posedge clk);
    pulse_frame();
    checks++;
    if (out_area2 !== 22'd0 || out_degen !== 1'b1 || out_sat !== 1'b0 || out_x2 !== 12'd10 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL degen area=%0d degen=%0b sat=%0b x2=%0d required 0/1/0/10", out_area2, out_degen, out_sat, out_x2);
    end
  endtask

  task automatic test_saturation();
    handshake(0, 0, 4095, 0, 0, 4095);
    repeat (4) @(posedge clk);
    pulse_frame();
    checks++;
    if (out_area2 !== 22'd4194303 || out_sat !== 1'b1 || out_degen !== 1'b0 || out_y3 !== 12'd4095) begin
      errors++;
      $display("FAIL saturate area=%0d sat=%0b degen=%0b y3=%0d required 4194303/1/0/4095", out_area2, out_sat, out_degen, out_y3);
    end
  endtask

  task automatic test_frame_gating();
    handshake(286, 36, 300, 300, 1000, 500);
    in_x1 = 12'd0; in_y1 = 12'd0; in_x2 = 12'd10; in_y2 = 12'd10; in_x3 = 12'd20; in_y3 = 12'd20;
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL gate_busy_ready in_ready=%0b busy=%0b required 0/1", in_ready, busy);
    end
    @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    @(negedge clk);
    checks++;
    if (out_area2 !== 22'd4194303 || out_x2 !== 12'd4095 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL gate_mul2_pulse area=%0d x2=%0d required 4194303/4095", out_area2, out_x2);
    end
    repeat (7) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_area2 !== 22'd4194303 || out_sat !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL gate_hold area=%0d sat=%0b in_ready=%0b required 4194303/1/0", out_area2, out_sat, in_ready);
    end
    in_valid = 1'b0;
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    @(negedge clk);
    checks++;
    if (out_area2 !== 22'd182000 || out_x1 !== 12'd286 || out_sat !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL gate_commit area=%0d x1=%0d sat=%0b required 182000/286/0", out_area2, out_x1, out_sat);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL gate_no_extra_accept busy=%0b in_ready=%0b required 0/1", busy, in_ready);
    end
  endtask

  task automatic test_reset_in_pend();
    handshake(0, 0, 4095, 0, 0, 4095);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_area2 !== 22'd182000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pend_before area=%0d busy=%0b required 182000/1", out_area2, busy);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_area2 !== 22'd0 || out_x1 !== 12'd0 || out_x3 !== 12'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_pend_clear area=%0d x1=%0d valid=%0b busy=%0b required 0/0/0/0", out_area2, out_x1, out_valid, busy);
    end
    pulse_frame();
    checks++;
    if (out_valid !== 1'b0 || out_area2 !== 22'd0 || out_x2 !== 12'd0 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL rst_pend_discard valid=%0b area=%0d x2=%0d sat=%0b required 0/0/0/0", out_valid, out_area2, out_x2, out_sat);
    end
  endtask

  initial begin
    test_reset();
    test_area();
    test_degenerate();
    test_saturation();
    test_frame_gating();
    test_reset_in_pend();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
